// File: rtl/gpr_pkg.sv
// Shared definitions for the GPR file: ABI register indices, reset-pattern
// encodings, pending-counter operations and the reset-value helper.
package gpr_pkg;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 1;
  localparam int unsigned REG_SP   = 2;
  localparam int unsigned REG_GP   = 3;
  localparam int unsigned REG_TP   = 4;
  localparam int unsigned REG_T0   = 5;
  localparam int unsigned REG_T1   = 6;
  localparam int unsigned REG_T2   = 7;
  localparam int unsigned REG_S0   = 8;
  localparam int unsigned REG_S1   = 9;
  localparam int unsigned REG_A0   = 10;
  localparam int unsigned REG_A1   = 11;
  localparam int unsigned REG_A2   = 12;

  localparam int unsigned RST_PAT_ZERO  = 0;
  localparam int unsigned RST_PAT_INDEX = 1;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // x0 is zero under every pattern; callers truncate/extend to XLEN.
  function automatic logic [63:0] gpr_rst_val(input int unsigned pat, input int unsigned idx);
    logic [63:0] val;
    val = 64'd0;
    if (idx != REG_ZERO && pat == RST_PAT_INDEX) begin
      val = 64'(idx);
    end else begin
      val = 64'd0;
    end
    return val;
  endfunction

endpackage

// File: rtl/gpr_pend_cnt.sv
// Saturating up/down counter tracking in-flight writes to one register.
module gpr_pend_cnt
  import gpr_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          full_o
);

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          inc_ok_s;
  logic          dec_ok_s;
  cnt_op_e       op_s;

  // A simultaneous decrement frees the slot, so a saturated inc+dec still holds.
  always_comb begin
    dec_ok_s = dec_i && (cnt_q != CNT_ZERO);
    inc_ok_s = inc_i && ((cnt_q != CNT_MAX) || dec_ok_s);
    if (inc_ok_s && !dec_ok_s) begin
      op_s = CNT_INC;
    end else if (dec_ok_s && !inc_ok_s) begin
      op_s = CNT_DEC;
    end else begin
      op_s = CNT_HOLD;
    end
    case (op_s)
      CNT_INC: cnt_d = cnt_q + CW'(1);
      CNT_DEC: cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/gpr_file_sb.sv
// RISC-V GPR file with bypassed combinational read ports, an un-bypassed
// debug port and per-register write-pending counters for hazard detection.
module gpr_file_sb
  import gpr_pkg::*;
#(
  parameter  int XLEN    = 64,
  parameter  int NREG    = 32,
  localparam int AW      = $clog2(NREG),
  parameter  int NRP     = 2,
  parameter  int CW      = 2,
  parameter  int RST_PAT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   rp_addr,
  output logic [NRP*XLEN-1:0] rp_data,
  output logic [NRP-1:0]      rp_busy,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_full,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  output logic                wb_err
);

  localparam logic [AW-1:0]   IDX_ZERO  = {AW{1'b0}};
  localparam logic [XLEN-1:0] DATA_ZERO = {XLEN{1'b0}};
  localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

  logic [XLEN-1:0] regs_q [NREG];
  logic [CW-1:0]   cnt_s  [NREG];
  logic            full_s [NREG];
  logic            wb_live_s;
  logic            wb_err_q;
  logic            wb_err_d;

  assign wb_live_s = wb_en && (wb_addr != IDX_ZERO);

  // A writeback to iss_rd in the same cycle releases one slot.
  assign iss_full = (iss_rd != IDX_ZERO) && full_s[iss_rd] && !(wb_en && (wb_addr == iss_rd));

  assign cnt_s[0]  = CNT_ZERO;
  assign full_s[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic inc_s;
    logic dec_s;
    assign inc_s = iss_en && (iss_rd == AW'(r)) && !iss_full;
    assign dec_s = wb_en && (wb_addr == AW'(r));
    gpr_pend_cnt #(
      .CW(CW)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (inc_s),
      .dec_i (dec_s),
      .cnt_o (cnt_s[r]),
      .full_o(full_s[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= XLEN'(gpr_rst_val(RST_PAT, i));
      end
    end else if (wb_live_s) begin
      regs_q[wb_addr] <= wb_data;
    end else begin
      regs_q[wb_addr] <= regs_q[wb_addr];
    end
  end

  // Data is still written on an unexpected writeback; only the flag records it.
  always_comb begin
    if (wb_live_s && (cnt_s[wb_addr] == CNT_ZERO)) begin
      wb_err_d = 1'b1;
    end else begin
      wb_err_d = wb_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_err_q <= 1'b0;
    end else begin
      wb_err_q <= wb_err_d;
    end
  end

  assign wb_err = wb_err_q;

  for (genvar k = 0; k < NRP; k++) begin : g_rp
    logic [AW-1:0]   a_s;
    logic            hit_s;
    logic [XLEN-1:0] data_s;
    logic            busy_s;

    assign a_s   = rp_addr[k*AW +: AW];
    assign hit_s = wb_en && (wb_addr == a_s);

    // The final outstanding write being bypassed this cycle clears busy.
    always_comb begin
      if (a_s == IDX_ZERO) begin
        data_s = DATA_ZERO;
        busy_s = 1'b0;
      end else if (hit_s) begin
        data_s = wb_data;
        busy_s = (cnt_s[a_s] != CNT_ZERO) && (cnt_s[a_s] != CNT_ONE);
      end else begin
        data_s = regs_q[a_s];
        busy_s = (cnt_s[a_s] != CNT_ZERO);
      end
    end

    assign rp_data[k*XLEN +: XLEN] = data_s;
    assign rp_busy[k]              = busy_s;
  end

  assign dbg_data = (dbg_addr == IDX_ZERO) ? DATA_ZERO : regs_q[dbg_addr];

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed and randomized checks of gpr_file_sb against an array-based model.
module tb_gpr_file_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRP  = 2;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRP*AW-1:0]   rp_addr;
  logic [NRP*XLEN-1:0] rp_data;
  logic [NRP-1:0]      rp_busy;
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic                iss_full;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;
  logic                wb_err;

  always #5 clk = ~clk;

  gpr_file_sb #(
    .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .CW(CW), .RST_PAT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .rp_addr(rp_addr), .rp_data(rp_data), .rp_busy(rp_busy),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_full(iss_full),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wb_err(wb_err)
  );

  logic [63:0] m_reg [NREG];
  int          m_cnt [NREG];
  bit          m_err;
  int          in_a [NRP];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i] = 64'(i);
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [63:0] exp_rd(input int a);
    if (a == 0) return 64'd0;
    if (wb_en && int'(wb_addr) == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (m_cnt[a] == 0) return 1'b0;
    if (wb_en && int'(wb_addr) == a && m_cnt[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_full();
    int r;
    r = int'(iss_rd);
    return (r != 0) && (m_cnt[r] == CMAX) && !(wb_en && int'(wb_addr) == r);
  endfunction

  task automatic set_in(input bit r, input bit we, input int wa, input logic [63:0] wd,
                        input bit ie, input int ir, input int a0, input int a1, input int da);
    rst      = r;
    wb_en    = we;
    wb_addr  = AW'(wa);
    wb_data  = wd;
    iss_en   = ie;
    iss_rd   = AW'(ir);
    in_a[0]  = a0;
    in_a[1]  = a1;
    rp_addr  = {AW'(a1), AW'(a0)};
    dbg_addr = AW'(da);
  endtask

  // Check combinational outputs, advance the model, clock, then check state.
  task automatic cycle();
    bit full_e;
    bit inc;
    bit dec;
    int wa;
    int ir;
    #1;
    for (int k = 0; k < NRP; k++) begin
      check_eq("rp_data", rp_data[k*XLEN +: XLEN], exp_rd(in_a[k]));
      check_eq("rp_busy", 64'(rp_busy[k]), 64'(exp_busy(in_a[k])));
    end
    full_e = exp_full();
    check_eq("iss_full", 64'(iss_full), 64'(full_e));
    wa = int'(wb_addr);
    ir = int'(iss_rd);
    if (rst) begin
      model_reset();
    end else begin
      inc = iss_en && ir != 0 && !full_e;
      dec = wb_en && wa != 0 && m_cnt[wa] != 0;
      if (wb_en && wa != 0 && m_cnt[wa] == 0) m_err = 1'b1;
      if (dec) m_cnt[wa] = m_cnt[wa] - 1;
      if (inc) m_cnt[ir] = m_cnt[ir] + 1;
      if (wb_en && wa != 0) m_reg[wa] = wb_data;
    end
    @(posedge clk);
    #1;
    check_eq("dbg_data", dbg_data, (dbg_addr == 0) ? 64'd0 : m_reg[dbg_addr]);
    check_eq("wb_err", 64'(wb_err), 64'(m_err));
  endtask

  task automatic idle(input int a0, input int a1, input int da);
    set_in(1'b0, 1'b0, 0, 64'd0, 1'b0, 0, a0, a1, da);
  endtask

  initial begin
    model_reset();
    set_in(1'b1, 1'b0, 0, 64'd0, 1'b0, 0, 0, 0, 5);
    @(negedge clk);
    cycle();
    check_eq("rst_dbg_x5", dbg_data, 64'd5);
    check_eq("rst_wb_err", 64'(wb_err), 64'd0);
    idle(5, 0, 0);
    #1;
    check_eq("rst_dbg_x0", dbg_data, 64'd0);
    check_eq("rst_busy", 64'(rp_busy), 64'd0);
    cycle();

    // bypass to x10 (issued first so the writeback is expected)
    set_in(1'b0, 1'b0, 0, 64'd0, 1'b1, 10, 0, 0, 10);
    cycle();
    set_in(1'b0, 1'b1, 10, 64'hDEAD_BEEF, 1'b0, 0, 10, 10, 10);
    #1;
    check_eq("bypass_data", rp_data[63:0], 64'hDEAD_BEEF);
    check_eq("bypass_dbg_old", dbg_data, 64'd10);
    check_eq("bypass_busy0", 64'(rp_busy[0]), 64'd0);
    cycle();
    check_eq("bypass_dbg_new", dbg_data, 64'hDEAD_BEEF);

    set_in(1'b0, 1'b1, 0, 64'h55, 1'b0, 0, 0, 0, 0);
    #1;
    check_eq("x0_bypass", rp_data[63:0], 64'd0);
    cycle();
    check_eq("x0_dbg", dbg_data, 64'd0);
    check_eq("x0_no_err", 64'(wb_err), 64'd0);

    // scoreboard on x7
    set_in(1'b0, 1'b0, 0, 64'd0, 1'b1, 7, 7, 0, 7);
    #1;
    check_eq("iss_same_cyc_busy", 64'(rp_busy[0]), 64'd0);
    cycle();
    set_in(1'b0, 1'b0, 0, 64'd0, 1'b1, 7, 7, 0, 7);
    #1;
    check_eq("iss_next_busy", 64'(rp_busy[0]), 64'd1);
    cycle();
    set_in(1'b0, 1'b1, 7, 64'h7777, 1'b0, 0, 7, 0, 7);
    #1;
    check_eq("wb1_busy", 64'(rp_busy[0]), 64'd1);
    cycle();
    set_in(1'b0, 1'b1, 7, 64'h8888, 1'b0, 0, 7, 0, 7);
    #1;
    check_eq("wb2_busy", 64'(rp_busy[0]), 64'd0);
    cycle();
    idle(7, 0, 7);
    #1;
    check_eq("x7_drained", 64'(rp_busy[0]), 64'd0);

    // saturation on x3
    for (int i = 0; i < CMAX; i++) begin
      set_in(1'b0, 1'b0, 0, 64'd0, 1'b1, 3, 0, 3, 3);
      cycle();
    end
    set_in(1'b0, 1'b0, 0, 64'd0, 1'b1, 3, 0, 3, 3);
    #1;
    check_eq("sat_full", 64'(iss_full), 64'd1);
    cycle();
    set_in(1'b0, 1'b1, 3, 64'h3333, 1'b1, 3, 0, 3, 3);
    #1;
    check_eq("sat_wb_frees", 64'(iss_full), 64'd0);
    cycle();
    set_in(1'b0, 1'b0, 0, 64'd0, 1'b0, 3, 0, 3, 3);
    #1;
    check_eq("sat_cnt_held", 64'(iss_full), 64'd1);
    cycle();

    // simultaneous issue and writeback on x12 with one pending
    set_in(1'b0, 1'b0, 0, 64'd0, 1'b1, 12, 12, 0, 12);
    cycle();
    set_in(1'b0, 1'b1, 12, 64'hC0FFEE, 1'b1, 12, 12, 0, 12);
    cycle();
    idle(12, 0, 12);
    #1;
    check_eq("x12_still_busy", 64'(rp_busy[0]), 64'd1);
    cycle();

    // unexpected writeback
    set_in(1'b0, 1'b1, 9, 64'h1234, 1'b0, 0, 0, 0, 9);
    cycle();
    check_eq("err_set", 64'(wb_err), 64'd1);
    check_eq("err_data", dbg_data, 64'h1234);

    // reset mid-run; strobes must be ignored
    set_in(1'b1, 1'b1, 5, 64'hFFFF, 1'b1, 6, 3, 12, 5);
    cycle();
    check_eq("rst2_err", 64'(wb_err), 64'd0);
    idle(3, 12, 5);
    #1;
    check_eq("rst2_busy", 64'(rp_busy), 64'd0);
    check_eq("rst2_dbg", dbg_data, 64'd5);
    cycle();

    // randomized traffic, biased to a few registers to create hazards
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 3);
      set_in(($urandom_range(0, 199) == 0),
             $urandom_range(0, 1),
             (sel == 0) ? $urandom_range(0, NREG - 1) : $urandom_range(0, 5),
             {$urandom, $urandom},
             $urandom_range(0, 1),
             (sel == 1) ? $urandom_range(0, NREG - 1) : $urandom_range(0, 5),
             $urandom_range(0, 5),
             $urandom_range(0, 5),
             $urandom_range(0, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
